calc_key_sequencer: RTL and testbench

- Upstream stage of the calculator ALU.
- Collects key events (digits, operator, equals, clear) into operand A, operator and operand B.
- Issues the one-hot ALU op code, sequences the ALU's multi-cycle busy handshake, then captures and holds the result for the display stage.
- Owns all ALU op timing. The ALU is never driven by anything else.

---
 rtl/calc_pkg.sv | 50 +++++
 rtl/calc_key_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_calc_key_sequencer.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator: key codes, one-hot ALU op codes,
// and the key sequencer state encoding.
package calc_pkg;

  // Key codes; 0x0-0x9 are digits.
  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_MUL = 4'hC;
  localparam logic [3:0] KEY_DIV = 4'hD;
  localparam logic [3:0] KEY_EQ  = 4'hE;
  localparam logic [3:0] KEY_CLR = 4'hF;

  // One-hot ALU op codes; all-zero means the ALU is idle.
  localparam logic [3:0] OP_ADD  = 4'b1000;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0001;
  localparam logic [3:0] OP_STOP = 4'b0000;

  typedef enum logic [2:0] {
    ST_ENTER_A   = 3'd0,
    ST_ENTER_B   = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_CAPTURE   = 3'd3,
    ST_WAIT_BUSY = 3'd4,
    ST_WAIT_DONE = 3'd5,
    ST_SHOW      = 3'd6
  } state_t;

  function automatic logic is_digit(input logic [3:0] k);
    return (k <= 4'h9);
  endfunction

  function automatic logic is_operator(input logic [3:0] k);
    return (k >= KEY_ADD) && (k <= KEY_DIV);
  endfunction

  function automatic logic [3:0] key_to_op(input logic [3:0] k);
    logic [3:0] op;
    case (k)
      KEY_ADD: op = OP_ADD;
      KEY_SUB: op = OP_SUB;
      KEY_MUL: op = OP_MUL;
      KEY_DIV: op = OP_DIV;
      default: op = OP_STOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/calc_key_sequencer.sv
// Key sequencer in front of the calculator ALU: gathers operand A, operator
// and operand B from key strobes, runs the ALU op handshake (single-cycle
// add/sub, multi-cycle busy-handshaked multiply) and holds the result.
//
// Key handshake: a key is taken on a rising clk edge where key_valid=1 and
// key_ready=1. key_ready depends on state only; a strobe seen while
// key_ready=0 is discarded, never queued.
module calc_key_sequencer
  import calc_pkg::*;
#(
  parameter int MUL_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  output logic [3:0] alu_op,
  output logic [3:0] alu_data1,
  output logic [3:0] alu_data2,
  input  logic [7:0] alu_o,
  input  logic       alu_busy,
  output logic [7:0] result,
  output logic       result_valid,
  output logic       err
);

  localparam int CNT_W = $clog2(MUL_TIMEOUT + 1);

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;          // latched operator as one-hot op
  logic [3:0]       alu_op_q, alu_op_d;
  logic [3:0]       a_q, a_d;
  logic [3:0]       b_q, b_d;
  logic [7:0]       result_q, result_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;        // cycles spent in WAIT_DONE
  logic             wb_cnt_q, wb_cnt_d;  // cycles spent in WAIT_BUSY
  logic             key_hit;

  assign key_ready    = (state_q == ST_ENTER_A) || (state_q == ST_ENTER_B) ||
                        (state_q == ST_SHOW);
  assign key_hit      = key_valid && key_ready;
  assign result_valid = (state_q == ST_SHOW);
  assign alu_op       = alu_op_q;
  assign alu_data1    = a_q;
  assign alu_data2    = b_q;
  assign result       = result_q;
  assign err          = err_q;

  // State and datapath registers; reset also forces the ALU op to STOP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_ENTER_A;
      op_q     <= OP_STOP;
      alu_op_q <= OP_STOP;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      wb_cnt_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      alu_op_q <= alu_op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      wb_cnt_q <= wb_cnt_d;
    end
  end

  // Next-state and datapath updates; everything holds unless a state acts.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    alu_op_d = alu_op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    wb_cnt_d = wb_cnt_q;

    case (state_q)
      ST_ENTER_A: begin
        if (key_hit) begin
          if (is_digit(key_code)) begin
            a_d   = key_code;
            err_d = 1'b0;
          end else if (is_operator(key_code)) begin
            op_d    = key_to_op(key_code);
            b_d     = '0;
            state_d = ST_ENTER_B;
          end else if (key_code == KEY_CLR) begin
            a_d   = '0;
            err_d = 1'b0;
          end
        end
      end

      ST_ENTER_B: begin
        if (key_hit) begin
          if (is_digit(key_code)) begin
            b_d   = key_code;
            err_d = 1'b0;
          end else if (is_operator(key_code)) begin
            op_d = key_to_op(key_code);
          end else if (key_code == KEY_CLR) begin
            a_d     = '0;
            b_d     = '0;
            op_d    = OP_STOP;
            err_d   = 1'b0;
            state_d = ST_ENTER_A;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end

      ST_ISSUE: begin
        if (op_q == OP_DIV) begin
          // No divider in the ALU: flag it and keep the previous result.
          err_d   = 1'b1;
          state_d = ST_SHOW;
        end else if (op_q == OP_MUL) begin
          alu_op_d = OP_MUL;
          wb_cnt_d = 1'b0;
          state_d  = ST_WAIT_BUSY;
        end else begin
          alu_op_d = op_q;
          state_d  = ST_CAPTURE;
        end
      end

      ST_CAPTURE: begin
        // Add/sub only produce 5 valid bits; the rest is left over from
        // whatever the ALU computed before.
        result_d = {3'b000, alu_o[4:0]};
        alu_op_d = OP_STOP;
        state_d  = ST_SHOW;
      end

      ST_WAIT_BUSY: begin
        if (alu_busy) begin
          cnt_d   = '0;
          state_d = ST_WAIT_DONE;
        end else if (wb_cnt_q) begin
          err_d    = 1'b1;
          alu_op_d = OP_STOP;
          state_d  = ST_SHOW;
        end else begin
          wb_cnt_d = 1'b1;
        end
      end

      ST_WAIT_DONE: begin
        if (!alu_busy) begin
          // Drop the op on this very edge: the ALU step counter wraps to 0
          // here, and a still-present MUL would start a new multiply.
          result_d = alu_o;
          alu_op_d = OP_STOP;
          state_d  = ST_SHOW;
        end else if (cnt_q == CNT_W'(MUL_TIMEOUT)) begin
          err_d    = 1'b1;
          alu_op_d = OP_STOP;
          state_d  = ST_SHOW;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_SHOW: begin
        if (key_hit) begin
          if (is_digit(key_code)) begin
            a_d     = key_code;
            err_d   = 1'b0;
            state_d = ST_ENTER_A;
          end else if (is_operator(key_code)) begin
            // Chain: the previous result becomes operand A.
            a_d     = result_q[3:0];
            op_d    = key_to_op(key_code);
            b_d     = '0;
            state_d = ST_ENTER_B;
          end else if (key_code == KEY_CLR) begin
            a_d      = '0;
            b_d      = '0;
            op_d     = OP_STOP;
            result_d = '0;
            err_d    = 1'b0;
            state_d  = ST_ENTER_A;
          end
        end
      end

      default: begin
        alu_op_d = OP_STOP;
        state_d  = ST_ENTER_A;
      end
    endcase
  end

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Directed bench for calc_key_sequencer with a small behavioural ALU stub:
// add/sub answer combinationally in the low 5 bits (upper bits stale),
// multiply runs a 10-step counter with busy, restarting if MUL is still
// presented after the counter wraps.
module tb_calc_key_sequencer;
  import calc_pkg::*;

  localparam int MUL_N = 10;

  logic       clk;
  logic       rst_n;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;
  logic [3:0] alu_op;
  logic [3:0] alu_data1;
  logic [3:0] alu_data2;
  logic [7:0] alu_o;
  logic       alu_busy;
  logic [7:0] result;
  logic       result_valid;
  logic       err;

  int n_tests;
  int n_fail;

  calc_key_sequencer #(.MUL_TIMEOUT(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .key_ready    (key_ready),
    .alu_op       (alu_op),
    .alu_data1    (alu_data1),
    .alu_data2    (alu_data2),
    .alu_o        (alu_o),
    .alu_busy     (alu_busy),
    .result       (result),
    .result_valid (result_valid),
    .err          (err)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- ALU stub ----------------
  int         step;
  logic       hang;
  logic [7:0] mul_out;
  logic [7:0] prod;
  logic [4:0] sum5;
  logic [4:0] dif5;

  assign prod = 8'($signed({{4{alu_data1[3]}}, alu_data1}) *
                   $signed({{4{alu_data2[3]}}, alu_data2}));
  assign sum5 = {1'b0, alu_data1} + {1'b0, alu_data2};
  assign dif5 = {1'b0, alu_data1} - {1'b0, alu_data2};
  assign alu_busy = hang ? 1'b1 : ((step != 0) && (step != MUL_N));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step    <= 0;
      mul_out <= 8'h00;
    end else if (alu_op == OP_MUL) begin
      if (step == MUL_N) begin
        step    <= 0;
        mul_out <= prod;
      end else begin
        step <= step + 1;
      end
    end else begin
      step <= 0;
    end
  end

  always_comb begin
    alu_o = mul_out;
    if (alu_op == OP_ADD)      alu_o = {mul_out[7:5], sum5};
    else if (alu_op == OP_SUB) alu_o = {mul_out[7:5], dif5};
    else if (step == MUL_N)    alu_o = prod;
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Called at a negedge; presents one key for one posedge.
  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  task automatic press4(input logic [3:0] k0, input logic [3:0] k1,
                        input logic [3:0] k2, input logic [3:0] k3);
    press(k0);
    press(k1);
    press(k2);
    press(k3);
  endtask

  // Waits (bounded) for SHOW; reports cycles taken and cycles with op != 0.
  task automatic wait_show(input string tag, output int cyc, output int op_cyc);
    cyc    = 0;
    op_cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cyc++;
      if (alu_op != OP_STOP) op_cyc++;
      if (result_valid) break;
    end
    check_eq({tag, "_reached_show"}, {31'd0, result_valid}, 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  int cyc;
  int op_cyc;

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    hang      = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'h0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);

    check_eq("rst_alu_op", {28'd0, alu_op}, 32'h0);
    check_eq("rst_data1", {28'd0, alu_data1}, 32'h0);
    check_eq("rst_data2", {28'd0, alu_data2}, 32'h0);
    check_eq("rst_result", {24'd0, result}, 32'h0);
    check_eq("rst_rvalid", {31'd0, result_valid}, 32'h0);
    check_eq("rst_err", {31'd0, err}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_key_ready", {31'd0, key_ready}, 32'h1);

    // Add: 3 + 4
    press4(4'h3, KEY_ADD, 4'h4, KEY_EQ);
    check_eq("add_issue_op", {28'd0, alu_op}, 32'h0);
    check_eq("add_issue_ready", {31'd0, key_ready}, 32'h0);
    wait_show("add", cyc, op_cyc);
    check_eq("add_latency", cyc, 32'd1 + 32'd1);
    check_eq("add_op_cycles", op_cyc, 32'd1);
    check_eq("add_result", {24'd0, result}, 32'h07);
    check_eq("add_op_after", {28'd0, alu_op}, 32'h0);

    // Multiply 7 * 3
    press4(4'h7, KEY_MUL, 4'h3, KEY_EQ);
    wait_show("mul1", cyc, op_cyc);
    check_eq("mul1_latency", cyc, 32'd12);
    check_eq("mul1_op_cycles", op_cyc, 32'd11);
    check_eq("mul1_result", {24'd0, result}, 32'h15);
    check_eq("mul1_op_after", {28'd0, alu_op}, 32'h0);
    @(negedge clk);
    check_eq("mul1_no_restart", {31'd0, alu_busy}, 32'h0);

    // Multiply 9 * 2 = -7 * 2
    press4(4'h9, KEY_MUL, 4'h2, KEY_EQ);
    wait_show("mul2", cyc, op_cyc);
    check_eq("mul2_result", {24'd0, result}, 32'hF2);
    check_eq("mul2_err", {31'd0, err}, 32'h0);
    @(negedge clk);
    check_eq("mul2_no_restart", {31'd0, alu_busy}, 32'h0);

    // Subtract 2 - 5; stale upper bits (111) from the last multiply
    press4(4'h2, KEY_SUB, 4'h5, KEY_EQ);
    wait_show("sub", cyc, op_cyc);
    check_eq("sub_result", {24'd0, result}, 32'h1D);

    // Divide: error, result unchanged, no op issued
    press4(4'h6, KEY_DIV, 4'h2, KEY_EQ);
    wait_show("div", cyc, op_cyc);
    check_eq("div_op_cycles", op_cyc, 32'd0);
    check_eq("div_err", {31'd0, err}, 32'h1);
    check_eq("div_result", {24'd0, result}, 32'h1D);

    // Multiply timeout: busy stuck high
    hang = 1'b1;
    press(4'h5);
    check_eq("digit_clears_err", {31'd0, err}, 32'h0);
    press4(KEY_MUL, 4'h3, KEY_EQ, KEY_EQ);
    // second EQ above landed in ISSUE/WAIT and is dropped; realign to EQ edge
    repeat (17) @(negedge clk);
    check_eq("tmo_err_early", {31'd0, err}, 32'h0);
    check_eq("tmo_op_held", {28'd0, alu_op}, {28'd0, OP_MUL});
    @(negedge clk);
    check_eq("tmo_err", {31'd0, err}, 32'h1);
    check_eq("tmo_op_dropped", {28'd0, alu_op}, 32'h0);
    check_eq("tmo_rvalid", {31'd0, result_valid}, 32'h1);
    check_eq("tmo_result", {24'd0, result}, 32'h1D);
    hang = 1'b0;

    // Clear ignored while multiplying
    press4(4'h7, KEY_MUL, 4'h3, KEY_EQ);
    repeat (4) @(negedge clk);
    check_eq("lock_ready", {31'd0, key_ready}, 32'h0);
    press(KEY_CLR);
    wait_show("lock", cyc, op_cyc);
    check_eq("lock_result", {24'd0, result}, 32'h15);
    check_eq("lock_data1", {28'd0, alu_data1}, 32'h7);

    // Chain from SHOW: result[3:0] + 1
    press(KEY_ADD);
    check_eq("chain_a", {28'd0, alu_data1}, 32'h5);
    press(4'h1);
    press(KEY_EQ);
    wait_show("chain", cyc, op_cyc);
    check_eq("chain_result", {24'd0, result}, 32'h06);

    // Reset in the middle of a multiply
    press4(4'h3, KEY_MUL, 4'h3, KEY_EQ);
    repeat (5) @(negedge clk);
    check_eq("mid_op_before", {28'd0, alu_op}, {28'd0, OP_MUL});
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_op", {28'd0, alu_op}, 32'h0);
    check_eq("mid_rst_result", {24'd0, result}, 32'h0);
    check_eq("mid_rst_data1", {28'd0, alu_data1}, 32'h0);
    check_eq("mid_rst_ready", {31'd0, key_ready}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    press4(4'h3, KEY_ADD, 4'h4, KEY_EQ);
    wait_show("post_rst", cyc, op_cyc);
    check_eq("post_rst_result", {24'd0, result}, 32'h07);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
